// File: rtl/timer_controller_if.sv
// Button inputs and display-facing outputs of the HH:MM:SS timer controller.
// The master side drives the buttons; the controller is the slave.
interface timer_controller_if;
  logic       i_btn_start;
  logic       i_btn_mode;
  logic       i_btn_inc;
  logic       i_btn_clr;
  logic [6:0] o_hours;
  logic [5:0] o_minutes;
  logic [5:0] o_seconds;
  logic       o_running;
  logic [2:0] o_edit_mask;
  logic       o_blink_phase;
  logic       o_tick;

  modport master (
    output i_btn_start, i_btn_mode, i_btn_inc, i_btn_clr,
    input  o_hours, o_minutes, o_seconds, o_running, o_edit_mask, o_blink_phase, o_tick
  );

  modport slave (
    input  i_btn_start, i_btn_mode, i_btn_inc, i_btn_clr,
    output o_hours, o_minutes, o_seconds, o_running, o_edit_mask, o_blink_phase, o_tick
  );
endinterface

// File: rtl/timer_controller.sv
// Run/pause/set control FSM for the HH:MM:SS timer: button edge detection,
// time registers, 1 Hz prescaler and blink generator for the field being edited.
module timer_controller #(
  parameter logic [31:0] CLK_FREQ = 32'd50_000_000,
  parameter logic [31:0] BLINK_HZ = 32'd2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  timer_controller_if.slave bus
);

  localparam logic [31:0] PRESC_LAST = CLK_FREQ - 32'd1;
  localparam logic [31:0] BLINK_HALF = CLK_FREQ / (32'd2 * BLINK_HZ);
  localparam logic [31:0] BLINK_LAST = (BLINK_HALF > 32'd0) ? BLINK_HALF - 32'd1 : 32'd0;

  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_SET_H, ST_SET_M, ST_SET_S} state_t;

  state_t      state_q, state_d;
  logic [6:0]  hours_q, hours_d;
  logic [5:0]  minutes_q, minutes_d;
  logic [5:0]  seconds_q, seconds_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;
  logic        tick_q, tick_d;
  logic        running_q, running_d;
  logic [2:0]  mask_q, mask_d;
  logic [3:0]  btn_prev_q;
  logic [3:0]  btn_s, rise_s;
  logic        do_clr, do_start, do_mode, do_inc;

  // Bit order {clr, start, mode, inc} doubles as the priority order.
  assign btn_s    = {bus.i_btn_clr, bus.i_btn_start, bus.i_btn_mode, bus.i_btn_inc};
  assign rise_s   = btn_s & ~btn_prev_q;
  assign do_clr   = rise_s[3];
  assign do_start = rise_s[2] & ~rise_s[3];
  assign do_mode  = rise_s[1] & ~(|rise_s[3:2]);
  assign do_inc   = rise_s[0] & ~(|rise_s[3:1]);

  // State register and all datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      hours_q     <= 7'd0;
      minutes_q   <= 6'd0;
      seconds_q   <= 6'd0;
      presc_q     <= 32'd0;
      blink_cnt_q <= 32'd0;
      phase_q     <= 1'b0;
      tick_q      <= 1'b0;
      running_q   <= 1'b0;
      mask_q      <= 3'b000;
      btn_prev_q  <= 4'b1111;
    end else begin
      state_q     <= state_d;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      tick_q      <= tick_d;
      running_q   <= running_d;
      mask_q      <= mask_d;
      btn_prev_q  <= btn_s;
    end
  end

  // Next-state, time update, blink and output decode.
  always_comb begin
    state_d     = state_q;
    hours_d     = hours_q;
    minutes_d   = minutes_q;
    seconds_d   = seconds_q;
    presc_d     = presc_q;
    tick_d      = 1'b0;
    blink_cnt_d = 32'd0;
    phase_d     = 1'b0;
    running_d   = 1'b0;
    mask_d      = 3'b000;

    if (do_clr) begin
      state_d   = ST_IDLE;
      hours_d   = 7'd0;
      minutes_d = 6'd0;
      seconds_d = 6'd0;
      presc_d   = 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (do_start)     state_d = ST_RUN;
          else if (do_mode) state_d = ST_SET_H;
          else              state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (do_start) begin
            state_d = ST_IDLE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = 32'd0;
            tick_d  = 1'b1;
            // Full carry chain resolves in this one cycle.
            if (seconds_q == 6'd59) begin
              seconds_d = 6'd0;
              if (minutes_q == 6'd59) begin
                minutes_d = 6'd0;
                hours_d   = (hours_q == 7'd99) ? 7'd0 : hours_q + 7'd1;
              end else begin
                minutes_d = minutes_q + 6'd1;
              end
            end else begin
              seconds_d = seconds_q + 6'd1;
            end
          end else begin
            presc_d = presc_q + 32'd1;
          end
        end
        ST_SET_H: begin
          if (do_start)     state_d = ST_RUN;
          else if (do_mode) state_d = ST_SET_M;
          else if (do_inc)  hours_d = (hours_q == 7'd99) ? 7'd0 : hours_q + 7'd1;
          else              state_d = ST_SET_H;
        end
        ST_SET_M: begin
          if (do_start)     state_d   = ST_RUN;
          else if (do_mode) state_d   = ST_SET_S;
          else if (do_inc)  minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
          else              state_d   = ST_SET_M;
        end
        ST_SET_S: begin
          if (do_start)     state_d   = ST_RUN;
          else if (do_mode) state_d   = ST_IDLE;
          else if (do_inc)  seconds_d = (seconds_q == 6'd59) ? 6'd0 : seconds_q + 6'd1;
          else              state_d   = ST_SET_S;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Blink restarts visible on entry from IDLE and free-runs across SET fields.
    if (state_d inside {ST_SET_H, ST_SET_M, ST_SET_S}) begin
      if (state_q == ST_IDLE) begin
        blink_cnt_d = 32'd0;
        phase_d     = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = 32'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 32'd1;
        phase_d     = phase_q;
      end
    end else begin
      blink_cnt_d = 32'd0;
      phase_d     = 1'b0;
    end

    case (state_d)
      ST_RUN:   running_d = 1'b1;
      ST_SET_H: mask_d    = 3'b100;
      ST_SET_M: mask_d    = 3'b010;
      ST_SET_S: mask_d    = 3'b001;
      default:  mask_d    = 3'b000;
    endcase
  end

  assign bus.o_hours       = hours_q;
  assign bus.o_minutes     = minutes_q;
  assign bus.o_seconds     = seconds_q;
  assign bus.o_running     = running_q;
  assign bus.o_edit_mask   = mask_q;
  assign bus.o_blink_phase = phase_q;
  assign bus.o_tick        = tick_q;

endmodule

// File: tb/tb_timer_controller.sv
// Self-checking bench for timer_controller (CLK_FREQ=10, BLINK_HZ=1) against a
// reference model that keeps time as total seconds and blink as age-in-SET.
module tb_timer_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  timer_controller_if bus ();

  timer_controller #(.CLK_FREQ(32'd10), .BLINK_HZ(32'd1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: mode 0=IDLE 1=RUN 2=SET_H 3=SET_M 4=SET_S
  int         m_mode, m_t, m_sub, m_age;
  bit         m_tick;
  logic [3:0] m_prev;

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_sub = 0; m_age = 0; m_tick = 1'b0; m_prev = 4'b1111;
  endtask

  // b = {clr, start, mode, inc}
  task automatic model_step(input logic [3:0] b);
    logic [3:0] r;
    int old, h, mi, s;
    r = b & ~m_prev;
    m_prev = b;
    old = m_mode;
    m_tick = 1'b0;
    h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
    if (r[3]) begin
      m_mode = 0; m_t = 0; m_sub = 0;
    end else if (r[2]) begin
      m_mode = (old == 1) ? 0 : 1;
    end else if (old == 1) begin
      m_sub = m_sub + 1;
      if (m_sub == 10) begin
        m_sub = 0; m_tick = 1'b1; m_t = (m_t + 1) % 360000;
      end
    end else if (r[1]) begin
      m_mode = (old == 0) ? 2 : ((old == 4) ? 0 : old + 1);
    end else if (r[0]) begin
      if (old == 2) m_t = m_t - h * 3600 + ((h + 1) % 100) * 3600;
      if (old == 3) m_t = m_t - mi * 60 + ((mi + 1) % 60) * 60;
      if (old == 4) m_t = m_t - s + (s + 1) % 60;
    end
    if (m_mode >= 2) m_age = (old == 0) ? 0 : m_age + 1;
    else             m_age = 0;
  endtask

  function automatic logic [24:0] model_vec();
    logic [6:0] h; logic [5:0] mi, s; logic [2:0] mk; logic ph;
    h  = 7'(m_t / 3600);
    mi = 6'((m_t / 60) % 60);
    s  = 6'(m_t % 60);
    mk = (m_mode == 2) ? 3'b100 : (m_mode == 3) ? 3'b010 : (m_mode == 4) ? 3'b001 : 3'b000;
    ph = (m_mode >= 2) && (((m_age / 5) % 2) == 0);
    return {h, mi, s, (m_mode == 1), mk, ph, m_tick};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {bus.o_hours, bus.o_minutes, bus.o_seconds, bus.o_running,
            bus.o_edit_mask, bus.o_blink_phase, bus.o_tick};
  endfunction

  task automatic cyc(input logic [3:0] b);
    {bus.i_btn_clr, bus.i_btn_start, bus.i_btn_mode, bus.i_btn_inc} = b;
    @(posedge clk);
    if (rst) model_step(b);
    else     model_reset();
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    cyc(b);
    cyc(4'b0000);
  endtask

  task automatic presses(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  task automatic test_reset();
    model_reset();
    {bus.i_btn_clr, bus.i_btn_start, bus.i_btn_mode, bus.i_btn_inc} = 4'b0000;
    #1;
    n_checks++;
    if (dut_vec() !== 25'd0) begin
      n_err++; $display("FAIL reset_outputs got %h exp %h", dut_vec(), 25'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    cyc(4'b0000);
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL reset_release got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_run();
    int ticks = 0;
    press(4'b0100);
    for (int i = 0; i < 29; i++) begin
      cyc(4'b0000);
      ticks += int'(bus.o_tick);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL run cyc %0d got %h exp %h", i, dut_vec(), model_vec());
      end
    end
    n_checks++;
    if (bus.o_seconds !== 6'd3 || bus.o_running !== 1'b1 || ticks != 3) begin
      n_err++; $display("FAIL run_30 sec %0d run %b ticks %0d exp 3 1 3", bus.o_seconds, bus.o_running, ticks);
    end
  endtask

  task automatic test_carry();
    press(4'b1000);
    press(4'b0010); press(4'b0010); presses(4'b0001, 59);
    press(4'b0010); presses(4'b0001, 59);
    press(4'b0100);
    for (int i = 0; i < 9; i++) cyc(4'b0000);
    n_checks++;
    if ({bus.o_hours, bus.o_minutes, bus.o_seconds} !== {7'd1, 6'd0, 6'd0} || dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL carry_1h got %h exp %h", dut_vec(), model_vec());
    end
    press(4'b1000);
    press(4'b0010); presses(4'b0001, 99);
    press(4'b0010); presses(4'b0001, 59);
    press(4'b0010); presses(4'b0001, 59);
    press(4'b0100);
    for (int i = 0; i < 9; i++) cyc(4'b0000);
    n_checks++;
    if ({bus.o_hours, bus.o_minutes, bus.o_seconds, bus.o_running} !== {7'd0, 6'd0, 6'd0, 1'b1} ||
        dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL carry_wrap got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_pause();
    int k;
    for (int rep = 0; rep < 4; rep++) begin
      k = int'($urandom_range(3, 25));
      press(4'b0100);
      for (int i = 0; i < k; i++) cyc(4'b0000);
      press(4'b0100);
      for (int i = 0; i < 50 + 15; i++) begin
        if (i == 50) cyc(4'b0100);
        else         cyc(4'b0000);
        n_checks++;
        if (dut_vec() !== model_vec()) begin
          n_err++; $display("FAIL pause rep %0d cyc %0d got %h exp %h", rep, i, dut_vec(), model_vec());
        end
      end
      press(4'b0100);
    end
  endtask

  task automatic test_edit();
    press(4'b1000);
    press(4'b0010); presses(4'b0001, 100);
    n_checks++;
    if (bus.o_hours !== 7'd0 || bus.o_edit_mask !== 3'b100) begin
      n_err++; $display("FAIL edit_hours h %0d mask %b exp 0 100", bus.o_hours, bus.o_edit_mask);
    end
    press(4'b0010); presses(4'b0001, 61);
    n_checks++;
    if (bus.o_minutes !== 6'd1 || bus.o_hours !== 7'd0 || bus.o_edit_mask !== 3'b010) begin
      n_err++; $display("FAIL edit_minutes m %0d h %0d mask %b exp 1 0 010", bus.o_minutes, bus.o_hours, bus.o_edit_mask);
    end
    press(4'b0010); press(4'b0010);
    n_checks++;
    if (bus.o_edit_mask !== 3'b000 || bus.o_blink_phase !== 1'b0 || dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL edit_exit got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_blink();
    press(4'b1000);
    cyc(4'b0010); cyc(4'b0000);
    cyc(4'b0010);
    n_checks++;
    if (bus.o_edit_mask !== 3'b010 || bus.o_blink_phase !== 1'b1) begin
      n_err++; $display("FAIL blink_enter mask %b ph %b exp 010 1", bus.o_edit_mask, bus.o_blink_phase);
    end
    for (int i = 0; i < 22; i++) begin
      cyc(4'b0000);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL blink cyc %0d got %h exp %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_priority();
    press(4'b1000);
    press(4'b0010); presses(4'b0001, 5);
    press(4'b0010); presses(4'b0001, 6);
    press(4'b0010); presses(4'b0001, 7);
    press(4'b0100);
    n_checks++;
    if ({bus.o_hours, bus.o_minutes, bus.o_seconds, bus.o_running} !== {7'd5, 6'd6, 6'd7, 1'b1}) begin
      n_err++; $display("FAIL prio_preload got %h exp 05:06:07 running", dut_vec());
    end
    cyc(4'b1100);
    cyc(4'b0000);
    n_checks++;
    if (dut_vec() !== 25'd0 || dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL prio_start_clr got %h exp %h", dut_vec(), 25'd0);
    end
    // Held mode+inc through reset must not produce an edge.
    cyc(4'b0011);
    rst = 1'b0;
    cyc(4'b0011);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cyc(4'b0011);
    n_checks++;
    if (dut_vec() !== 25'd0 || dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL held_thru_reset got %h exp %h", dut_vec(), 25'd0);
    end
    cyc(4'b0000);
  endtask

  task automatic test_random();
    logic [3:0] b;
    for (int i = 0; i < 3000; i++) begin
      b[3] = ($urandom_range(0, 299) == 0);
      b[2] = ($urandom_range(0, 99) < 3);
      b[1] = ($urandom_range(0, 99) < 5);
      b[0] = ($urandom_range(0, 99) < 20);
      cyc(b);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL random cyc %0d btn %b got %h exp %h", i, b, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    press(4'b1000);
    press(4'b0100);
    for (int i = 0; i < 27; i++) cyc(4'b0000);
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec() !== 25'd0) begin
      n_err++; $display("FAIL async_reset got %h exp %h", dut_vec(), 25'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(4'b0000);
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL async_release got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_carry();
    test_pause();
    test_edit();
    test_blink();
    test_priority();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
